// File: rtl/uart_fifo_ctl_if.sv
// Purpose : core-side register bus for uart_fifo_ctl (address, write data, strobes, read data).
// Latency : none; plain wires bundled for port grouping.
// Backpres: none; the slave never stalls the core.
// Modports: master = core side (drives address/data/strobes), slave = UART side (drives mem_rdata).
interface uart_fifo_ctl_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output mem_re,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/uart_fifo_ctl.sv
// Purpose : memory-mapped UART with TX/RX FIFOs, programmable baud divisor and level interrupt.
// Latency : register reads are combinational; an idle TX line starts a frame 2 cycles after a DATA write.
// Backpres: never stalls the bus; DATA writes to a full TX FIFO are dropped, RX bytes into a full FIFO set overrun.
// Ports   : clk, rst (synchronous, active-high); bus (slave modport: mem_addr, mem_wdata, mem_we,
//           mem_re, mem_rdata); uart_tx serial out (idle high); uart_rx asynchronous serial in;
//           irq level interrupt.
// Option  : define UART_FIFO_PARITY_EN for an even-parity bit after the data bits (8E1); default is 8N1.
module uart_fifo_ctl #(
  parameter logic [31:0] UART_BASE_ADDR = 32'h4000_0000,
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [15:0] DIV_RESET      = 16'd434
) (
  input  logic           clk,
  input  logic           rst,
  uart_fifo_ctl_if.slave bus,
  output logic           uart_tx,
  input  logic           uart_rx,
  output logic           irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  // ---------------------------------------------------------------------------
  // Bus decode. Strobes are edge-detected so a held strobe acts exactly once.
  // ---------------------------------------------------------------------------
  logic       we_q, re_q;
  logic       we_pulse, re_pulse, hit;
  logic [1:0] sel;
  logic       wr_data, wr_stat, wr_div, wr_ien, rd_data;

  assign hit      = (bus.mem_addr[31:4] == UART_BASE_ADDR[31:4]);
  assign sel      = bus.mem_addr[3:2];
  assign we_pulse = bus.mem_we & ~we_q;
  assign re_pulse = bus.mem_re & ~re_q;
  assign wr_data  = we_pulse & hit & (sel == 2'd0);
  assign wr_stat  = we_pulse & hit & (sel == 2'd1);
  assign wr_div   = we_pulse & hit & (sel == 2'd2);
  assign wr_ien   = we_pulse & hit & (sel == 2'd3);
  assign rd_data  = re_pulse & hit & (sel == 2'd0);

  logic unused_bits;
  assign unused_bits = ^{bus.mem_addr[1:0], bus.mem_wdata[31:16]};

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q <= 1'b0;
      re_q <= 1'b0;
    end else begin
      we_q <= bus.mem_we;
      re_q <= bus.mem_re;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  logic [15:0] div_q;
  logic [1:0]  irq_en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= DIV_RESET;
      irq_en_q <= 2'b00;
    end else begin
      // Divisors below 4 leave no room for the half-bit start validation.
      if (wr_div)
        div_q <= (bus.mem_wdata[15:0] < 16'd4) ? 16'd4 : bus.mem_wdata[15:0];
      if (wr_ien)
        irq_en_q <= bus.mem_wdata[1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO. Pointers carry one extra wrap bit: equal pointers mean empty,
  // pointers differing only in the wrap bit mean full.
  // ---------------------------------------------------------------------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_q, tx_rd_q;
  logic          tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]    tx_head;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign tx_head  = tx_mem[tx_rd_q[AW-1:0]];
  // A pop in the same cycle frees the slot the write lands in.
  assign tx_push  = wr_data & (~tx_full | tx_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= bus.mem_wdata[7:0];
  end

  // ---------------------------------------------------------------------------
  // TX FSM. Each bit lasts tx_div_q clocks (counter runs 1..div). The divisor
  // is latched when a byte is popped, so a DIV write never disturbs a frame.
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_PAR   = 3'd3,
    TX_STOP  = 3'd4
  } tx_state_e;

`ifdef UART_FIFO_PARITY_EN
  localparam tx_state_e TX_AFTER_DATA = TX_PAR;
`else
  localparam tx_state_e TX_AFTER_DATA = TX_STOP;
`endif

  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_div_q, tx_cnt_q;
  logic [2:0]  tx_idx_q;
  logic [7:0]  tx_sh_q;
  logic        tx_q, tx_d;
  logic        tx_bit_done;
`ifdef UART_FIFO_PARITY_EN
  logic        tx_par_q;
`endif

  assign tx_bit_done = (tx_cnt_q == tx_div_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      TX_IDLE:  if (!tx_empty) tx_state_d = TX_START;
      TX_START: if (tx_bit_done) tx_state_d = TX_DATA;
      TX_DATA:  if (tx_bit_done && (tx_idx_q == 3'd7)) tx_state_d = TX_AFTER_DATA;
`ifdef UART_FIFO_PARITY_EN
      TX_PAR:   if (tx_bit_done) tx_state_d = TX_STOP;
`endif
      // Chain straight into the next start bit so frames are back-to-back.
      TX_STOP:  if (tx_bit_done) tx_state_d = tx_empty ? TX_IDLE : TX_START;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_d   = 1'b1;
    tx_pop = 1'b0;
    unique case (tx_state_q)
      TX_IDLE:  tx_pop = ~tx_empty;
      TX_START: tx_d   = 1'b0;
      TX_DATA:  tx_d   = tx_sh_q[0];
`ifdef UART_FIFO_PARITY_EN
      TX_PAR:   tx_d   = tx_par_q;
`endif
      TX_STOP:  tx_pop = tx_bit_done & ~tx_empty;
      default:  tx_d   = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt_q <= 16'd1;
      tx_idx_q <= 3'd0;
      tx_sh_q  <= 8'h00;
      tx_div_q <= DIV_RESET;
`ifdef UART_FIFO_PARITY_EN
      tx_par_q <= 1'b0;
`endif
    end else if (tx_pop) begin
      tx_cnt_q <= 16'd1;
      tx_idx_q <= 3'd0;
      tx_sh_q  <= tx_head;
      tx_div_q <= div_q;
`ifdef UART_FIFO_PARITY_EN
      tx_par_q <= ^tx_head;
`endif
    end else if (tx_state_q != TX_IDLE) begin
      if (tx_bit_done) begin
        tx_cnt_q <= 16'd1;
        if (tx_state_q == TX_DATA) begin
          tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
          tx_idx_q <= tx_idx_q + 3'd1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + 16'd1;
      end
    end
  end

  assign uart_tx = tx_q;

  // ---------------------------------------------------------------------------
  // RX synchroniser and falling-edge detect (all flops idle high).
  // ---------------------------------------------------------------------------
  logic rx_s1_q, rx_s2_q, rx_prev_q, rx_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_s2_q;

  // ---------------------------------------------------------------------------
  // RX FSM. The counter starts at 1 on the edge cycle: the start bit is
  // re-checked at div/2, then every later bit is sampled div clocks apart.
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_PAR   = 3'd3,
    RX_STOP  = 3'd4
  } rx_state_e;

`ifdef UART_FIFO_PARITY_EN
  localparam rx_state_e RX_AFTER_DATA = RX_PAR;
`else
  localparam rx_state_e RX_AFTER_DATA = RX_STOP;
`endif

  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_div_q, rx_cnt_q, rx_half;
  logic [2:0]  rx_idx_q;
  logic [7:0]  rx_sh_q;
  logic        rx_sample, rx_good, set_ferr, rx_push_q;
`ifdef UART_FIFO_PARITY_EN
  logic        rx_par_bad_q, set_perr;
`endif

  assign rx_half   = {1'b0, rx_div_q[15:1]};
  assign rx_sample = (rx_state_q == RX_START) ? (rx_cnt_q == rx_half)
                                              : (rx_cnt_q == rx_div_q);

  always_ff @(posedge clk) begin
    if (rst) rx_state_q <= RX_IDLE;
    else     rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      RX_IDLE:  if (rx_fall) rx_state_d = RX_START;
      // A start bit that reads high again at mid-bit was a glitch.
      RX_START: if (rx_sample) rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_sample && (rx_idx_q == 3'd7)) rx_state_d = RX_AFTER_DATA;
`ifdef UART_FIFO_PARITY_EN
      RX_PAR:   if (rx_sample) rx_state_d = RX_STOP;
`endif
      // Return at mid-stop so the next start edge is not missed.
      RX_STOP:  if (rx_sample) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_good  = 1'b0;
    set_ferr = 1'b0;
`ifdef UART_FIFO_PARITY_EN
    set_perr = 1'b0;
`endif
    if ((rx_state_q == RX_STOP) && rx_sample) begin
      if (!rx_s2_q) set_ferr = 1'b1;
`ifdef UART_FIFO_PARITY_EN
      else if (rx_par_bad_q) set_perr = 1'b1;
`endif
      else rx_good = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt_q  <= 16'd1;
      rx_idx_q  <= 3'd0;
      rx_sh_q   <= 8'h00;
      rx_div_q  <= DIV_RESET;
      rx_push_q <= 1'b0;
`ifdef UART_FIFO_PARITY_EN
      rx_par_bad_q <= 1'b0;
`endif
    end else begin
      rx_push_q <= rx_good;
      if (rx_state_q == RX_IDLE) begin
        if (rx_fall) begin
          rx_cnt_q <= 16'd1;
          rx_div_q <= div_q;
        end
      end else if (rx_sample) begin
        rx_cnt_q <= 16'd1;
        if (rx_state_q == RX_START) rx_idx_q <= 3'd0;
        if (rx_state_q == RX_DATA) begin
          rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
          rx_idx_q <= rx_idx_q + 3'd1;
        end
`ifdef UART_FIFO_PARITY_EN
        if (rx_state_q == RX_PAR) rx_par_bad_q <= ^{rx_sh_q, rx_s2_q};
`endif
      end else begin
        rx_cnt_q <= rx_cnt_q + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wr_q, rx_rd_q, rx_count;
  logic          rx_full, rx_empty, rx_push, rx_pop, set_ovr;
  logic [7:0]    rx_head;

  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
  assign rx_count = rx_wr_q - rx_rd_q;
  assign rx_head  = rx_mem[rx_rd_q[AW-1:0]];
  assign rx_pop   = rd_data & ~rx_empty;
  // A simultaneous pop makes room, so a full FIFO being read is not an overrun.
  assign rx_push  = rx_push_q & (~rx_full | rx_pop);
  assign set_ovr  = rx_push_q & rx_full & ~rx_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_q <= '0;
      rx_rd_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q[AW-1:0]] <= rx_sh_q;
  end

  // ---------------------------------------------------------------------------
  // Sticky status flags: a new event in the same cycle wins over a clear.
  // ---------------------------------------------------------------------------
  logic overrun_q, frame_err_q, parity_err;
`ifdef UART_FIFO_PARITY_EN
  logic parity_err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_FIFO_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      if (set_ovr)                              overrun_q   <= 1'b1;
      else if (wr_stat && bus.mem_wdata[4])     overrun_q   <= 1'b0;
      if (set_ferr)                             frame_err_q <= 1'b1;
      else if (wr_stat && bus.mem_wdata[7])     frame_err_q <= 1'b0;
`ifdef UART_FIFO_PARITY_EN
      if (set_perr)                             parity_err_q <= 1'b1;
      else if (wr_stat && bus.mem_wdata[6])     parity_err_q <= 1'b0;
`endif
    end
  end

`ifdef UART_FIFO_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read mux and interrupt
  // ---------------------------------------------------------------------------
  logic [31:0] status;
  logic [31:0] rdata;

  assign status = {16'h0000, 8'(rx_count), frame_err_q, parity_err,
                   (tx_state_q != TX_IDLE), overrun_q,
                   rx_empty, rx_full, tx_empty, tx_full};

  always_comb begin
    rdata = 32'h0;
    if (bus.mem_re && hit) begin
      unique case (sel)
        2'd0:    rdata = rx_empty ? 32'h0 : {1'b1, 23'h0, rx_head};
        2'd1:    rdata = status;
        2'd2:    rdata = {16'h0000, div_q};
        default: rdata = {30'h0, irq_en_q};
      endcase
    end
  end

  assign bus.mem_rdata = rdata;
  assign irq = (irq_en_q[0] & ~rx_empty) | (irq_en_q[1] & tx_empty);

endmodule
